// File: rtl/nios_2_pkg.sv
// nios_2_pkg: shared definitions for the nios_2 load/store unit.
//   - access size encodings (LSU_BYTE / LSU_HALF / LSU_WORD)
//   - LSU state enum
//   - alignment helpers used when a request is accepted
package nios_2_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR      = 2'd3
  } lsu_state_e;

  // Halfwords need addr[0]=0. Words (and the unused 2'b11 encoding,
  // handled as a word) need addr[1:0]=0. Bytes are always aligned.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic res;
    case (size)
      LSU_BYTE: res = 1'b0;
      LSU_HALF: res = addr_lo[0];
      default:  res = (addr_lo != 2'b00);
    endcase
    return res;
  endfunction

  // Byte and halfword stores need a read-modify-write.
  function automatic logic lsu_is_subword(input logic [1:0] size);
    return (size == LSU_BYTE) || (size == LSU_HALF);
  endfunction

endpackage

// File: rtl/nios_2_lsu_align.sv
// nios_2_lsu_align: combinational lane logic for the LSU.
//   i_word      : word read from data memory
//   i_addr_lo   : byte offset within the word (little-endian lanes)
//   i_size      : access size (LSU_BYTE / LSU_HALF / LSU_WORD)
//   i_signed    : sign-extend a sub-word load
//   i_wdata     : right-justified store data
//   o_load_data : selected lane, sign/zero extended (whole word for words)
//   o_merged    : i_word with the store lane(s) replaced (i_wdata for words)
module nios_2_lsu_align
  import nios_2_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_word[{i_addr_lo, 3'b000} +: 8];
    // A halfword lives in lane addr[1]; addr[0] is known to be 0 here.
    w_half      = i_word[{i_addr_lo[1], 4'b0000} +: 16];
    o_load_data = i_word;
    o_merged    = i_wdata;
    case (i_size)
      LSU_BYTE: begin
        o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged    = i_word;
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      LSU_HALF: begin
        o_load_data = {{16{i_signed & w_half[15]}}, w_half};
        o_merged    = i_word;
        o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nios_2_lsu.sv
// nios_2_lsu: load/store unit between execute and the data-memory port.
//   clk, rst            : clock, asynchronous active-low reset
//   req_*               : request from execute (valid/ready handshake)
//   resp_*              : one-cycle load result pulse with destination reg
//   err_o               : one-cycle pulse for a misaligned request
//   data_mem_*          : word-wide memory port, no byte enables
//   dbg_state_o         : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; all req_* fields are latched on that edge. The
// source must hold the request stable until it transfers. req_ready_o is 1
// exactly when the FSM is idle.
module nios_2_lsu
  import nios_2_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              err_o,
  output logic              data_mem_rd_o,
  output logic              data_mem_wr_o,
  output logic [ADDR_W-1:0] data_mem_addr_o,
  output logic [31:0]       data_mem_wdata_o,
  input  logic [31:0]       data_mem_rdata_i,
  output lsu_state_e        dbg_state_o
);

  // Last count value of RD_WAIT; data is valid on that cycle's closing edge.
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  lsu_state_e  r_state;
  logic [2:0]  r_lat_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;

  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign req_ready_o = (r_state == ST_IDLE);
  assign dbg_state_o = r_state;

  // Lane logic works directly on the live read data so the result is
  // registered on the same edge that samples it.
  nios_2_lsu_align u_align (
    .i_word      (data_mem_rdata_i),
    .i_addr_lo   (r_addr_lo),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_lat_cnt        <= 3'd0;
      r_we             <= 1'b0;
      r_size           <= LSU_BYTE;
      r_signed         <= 1'b0;
      r_addr_lo        <= 2'b00;
      r_wdata          <= 32'd0;
      r_rd             <= 5'd0;
      resp_valid_o     <= 1'b0;
      resp_data_o      <= 32'd0;
      resp_rd_o        <= 5'd0;
      err_o            <= 1'b0;
      data_mem_rd_o    <= 1'b0;
      data_mem_wr_o    <= 1'b0;
      data_mem_addr_o  <= '0;
      data_mem_wdata_o <= 32'd0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      data_mem_rd_o <= 1'b0;
      data_mem_wr_o <= 1'b0;
      resp_valid_o  <= 1'b0;
      err_o         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
              err_o <= 1'b1;
            end else begin
              r_we            <= req_we_i;
              r_size          <= req_size_i;
              r_signed        <= req_signed_i;
              r_addr_lo       <= req_addr_i[1:0];
              r_wdata         <= req_wdata_i;
              r_rd            <= req_rd_i;
              data_mem_addr_o <= {req_addr_i[ADDR_W-1:2], 2'b00};
              if (req_we_i && !lsu_is_subword(req_size_i)) begin
                data_mem_wr_o    <= 1'b1;
                data_mem_wdata_o <= req_wdata_i;
                r_state          <= ST_WR;
              end else begin
                // Loads and sub-word stores both start with a read.
                data_mem_rd_o <= 1'b1;
                r_state       <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          r_lat_cnt <= 3'd0;
          r_state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            if (r_we) begin
              data_mem_wr_o    <= 1'b1;
              data_mem_wdata_o <= w_merged;
              r_state          <= ST_WR;
            end else begin
              resp_valid_o <= 1'b1;
              resp_data_o  <= w_load_data;
              resp_rd_o    <= r_rd;
              r_state      <= ST_IDLE;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        ST_WR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_2_lsu.sv
// tb_nios_2_lsu: directed bench for nios_2_lsu. Instance a uses
// READ_LATENCY=1, instance b uses READ_LATENCY=3. Every memory-port event
// and response is stamped with its cycle number and checked in order
// against hand-computed expectations.
module tb_nios_2_lsu;
  import nios_2_pkg::*;

  localparam int W = 72;
  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_RESP = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // ---------------- instance a (latency 1) ----------------
  logic        valid_a, ready_a, we_a, sgn_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, wdata_a;
  logic [4:0]  rdi_a;
  logic        resp_valid_a, err_a, mrd_a, mwr_a;
  logic [31:0] resp_data_a, maddr_a, mwdata_a, mrdata_a;
  logic [4:0]  resp_rd_a;
  lsu_state_e  dbg_a;

  nios_2_lsu #(.READ_LATENCY(1), .ADDR_W(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(valid_a), .req_ready_o(ready_a), .req_we_i(we_a),
    .req_size_i(size_a), .req_signed_i(sgn_a), .req_addr_i(addr_a),
    .req_wdata_i(wdata_a), .req_rd_i(rdi_a),
    .resp_valid_o(resp_valid_a), .resp_data_o(resp_data_a), .resp_rd_o(resp_rd_a),
    .err_o(err_a), .data_mem_rd_o(mrd_a), .data_mem_wr_o(mwr_a),
    .data_mem_addr_o(maddr_a), .data_mem_wdata_o(mwdata_a),
    .data_mem_rdata_i(mrdata_a), .dbg_state_o(dbg_a)
  );

  // ---------------- instance b (latency 3) ----------------
  logic        valid_b, ready_b, we_b, sgn_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b;
  logic [4:0]  rdi_b;
  logic        resp_valid_b, err_b, mrd_b, mwr_b;
  logic [31:0] resp_data_b, maddr_b, mwdata_b, mrdata_b;
  logic [4:0]  resp_rd_b;
  lsu_state_e  dbg_b;

  nios_2_lsu #(.READ_LATENCY(3), .ADDR_W(32)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(valid_b), .req_ready_o(ready_b), .req_we_i(we_b),
    .req_size_i(size_b), .req_signed_i(sgn_b), .req_addr_i(addr_b),
    .req_wdata_i(wdata_b), .req_rd_i(rdi_b),
    .resp_valid_o(resp_valid_b), .resp_data_o(resp_data_b), .resp_rd_o(resp_rd_b),
    .err_o(err_b), .data_mem_rd_o(mrd_b), .data_mem_wr_o(mwr_b),
    .data_mem_addr_o(maddr_b), .data_mem_wdata_o(mwdata_b),
    .data_mem_rdata_i(mrdata_b), .dbg_state_o(dbg_b)
  );

  // ---------------- memory models ----------------
  // Read data is valid exactly READ_LATENCY cycles after the sampled
  // strobe; other cycles return a poison pattern.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) pipe_a <= mrd_a ? mem_a[maddr_a[7:2]] : 32'hDEAD_BEEF;
  assign mrdata_a = pipe_a;

  always @(posedge clk) begin
    pipe_b[0] <= mrd_b ? mem_b[maddr_b[7:2]] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrdata_b = pipe_b[2];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] mk(input logic inst, input logic [1:0] kind,
                                      input logic [15:0] c, input logic [15:0] a,
                                      input logic [31:0] d, input logic [4:0] r);
    return {inst, kind, c, a, d, r};
  endfunction

  task automatic push(input logic [W-1:0] item);
    exp_q.push_back(item);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic observe(input logic [W-1:0] obs);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL evt_unexpected: got=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL evt: got=%h expected=%h", obs, e);
      end
    end
  endtask

  // Monitors: every strobe/pulse becomes a stamped event.
  always @(negedge clk) begin
    if (rst) begin
      if (mrd_a)        observe(mk(1'b0, K_RD,   cyc, maddr_a[15:0], 32'd0, 5'd0));
      if (mwr_a)        observe(mk(1'b0, K_WR,   cyc, maddr_a[15:0], mwdata_a, 5'd0));
      if (resp_valid_a) observe(mk(1'b0, K_RESP, cyc, 16'd0, resp_data_a, resp_rd_a));
      if (err_a)        observe(mk(1'b0, K_ERR,  cyc, 16'd0, 32'd0, 5'd0));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mrd_b)        observe(mk(1'b1, K_RD,   cyc, maddr_b[15:0], 32'd0, 5'd0));
      if (mwr_b)        observe(mk(1'b1, K_WR,   cyc, maddr_b[15:0], mwdata_b, 5'd0));
      if (resp_valid_b) observe(mk(1'b1, K_RESP, cyc, 16'd0, resp_data_b, resp_rd_b));
      if (err_b)        observe(mk(1'b1, K_ERR,  cyc, 16'd0, 32'd0, 5'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic inst, input logic v, input logic we,
                       input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [4:0] rd);
    if (!inst) begin
      valid_a = v; we_a = we; size_a = sz; sgn_a = sg; addr_a = ad; wdata_a = wd; rdi_a = rd;
    end else begin
      valid_b = v; we_b = we; size_b = sz; sgn_b = sg; addr_b = ad; wdata_b = wd; rdi_b = rd;
    end
  endtask

  // Holds the request until accepted; c0 is the cycle ending with the
  // accept edge. Returns 1 time unit after that edge (inside C1).
  task automatic issue(input logic inst, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [4:0] rd, output logic [15:0] c0);
    bit done;
    int n;
    done = 0;
    n = 0;
    c0 = 16'd0;
    @(negedge clk);
    drive(inst, 1'b1, we, sz, sg, ad, wd, rd);
    while (!done && n < 60) begin
      if ((inst ? ready_b : ready_a) === 1'b1) begin
        c0 = cyc;
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    drive(inst, 1'b0, we, sz, sg, ad, wd, rd);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL accept_timeout: got=not_accepted expected=accepted addr=%h", ad);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d_pending expected=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] c0;
    logic [15:0] c1;

    drive(1'b0, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'd0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[8]  = 32'h0000_0005;   // 0x20
    mem_a[9]  = 32'h0000_0003;   // 0x24
    mem_a[10] = 32'h0080_0000;   // 0x28
    mem_a[11] = 32'h8001_7F00;   // 0x2C
    mem_b[16] = 32'd2;           // 0x40
    mem_b[17] = 32'd14;          // 0x44

    // Reset state
    #3 rst = 1'b0;
    #1;
    check("rst_ready_a", {31'd0, ready_a}, 32'd1);
    check("rst_rd_a", {31'd0, mrd_a}, 32'd0);
    check("rst_wr_a", {31'd0, mwr_a}, 32'd0);
    check("rst_resp_a", {31'd0, resp_valid_a}, 32'd0);
    check("rst_err_a", {31'd0, err_a}, 32'd0);
    check("rst_addr_a", maddr_a, 32'd0);
    check("rst_ready_b", {31'd0, ready_b}, 32'd1);
    check("rst_state_b", 32'(dbg_b), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Word load 0x20 -> 5, rd 6
    issue(1'b0, 1'b0, LSU_WORD, 1'b0, 32'h20, 32'd0, 5'd6, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h20, 32'd0, 5'd0));
    push(mk(1'b0, K_RESP, c0 + 16'd3, 16'd0, 32'd5, 5'd6));
    drain();

    // Byte store 0xAB to 0x25 over 0x00000003 -> 0x0000AB03
    issue(1'b0, 1'b1, LSU_BYTE, 1'b0, 32'h25, 32'h1234_56AB, 5'd9, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h24, 32'd0, 5'd0));
    push(mk(1'b0, K_WR, c0 + 16'd3, 16'h24, 32'h0000_AB03, 5'd0));
    drain();

    // Byte load 0x2A of 0x00800000, signed and unsigned
    issue(1'b0, 1'b0, LSU_BYTE, 1'b1, 32'h2A, 32'd0, 5'd1, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h28, 32'd0, 5'd0));
    push(mk(1'b0, K_RESP, c0 + 16'd3, 16'd0, 32'hFFFF_FF80, 5'd1));
    drain();
    issue(1'b0, 1'b0, LSU_BYTE, 1'b0, 32'h2A, 32'd0, 5'd2, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h28, 32'd0, 5'd0));
    push(mk(1'b0, K_RESP, c0 + 16'd3, 16'd0, 32'h0000_0080, 5'd2));
    drain();

    // Halfword loads from 0x80017F00: signed upper lane, unsigned lower lane
    issue(1'b0, 1'b0, LSU_HALF, 1'b1, 32'h2E, 32'd0, 5'd3, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h2C, 32'd0, 5'd0));
    push(mk(1'b0, K_RESP, c0 + 16'd3, 16'd0, 32'hFFFF_8001, 5'd3));
    drain();
    issue(1'b0, 1'b0, LSU_HALF, 1'b0, 32'h2C, 32'd0, 5'd4, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h2C, 32'd0, 5'd0));
    push(mk(1'b0, K_RESP, c0 + 16'd3, 16'd0, 32'h0000_7F00, 5'd4));
    drain();

    // Halfword store 0xBEEF to 0x2E -> 0xBEEF7F00
    issue(1'b0, 1'b1, LSU_HALF, 1'b0, 32'h2E, 32'hFFFF_BEEF, 5'd0, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h2C, 32'd0, 5'd0));
    push(mk(1'b0, K_WR, c0 + 16'd3, 16'h2C, 32'hBEEF_7F00, 5'd0));
    drain();

    // Word store: write in C1, ready again in C2
    issue(1'b0, 1'b1, LSU_WORD, 1'b0, 32'h30, 32'hCAFE_F00D, 5'd0, c0);
    push(mk(1'b0, K_WR, c0 + 16'd1, 16'h30, 32'hCAFE_F00D, 5'd0));
    check("ws_busy_c1", {31'd0, ready_a}, 32'd0);
    @(posedge clk);
    #1;
    check("ws_ready_c2", {31'd0, ready_a}, 32'd1);
    drain();

    // Misaligned halfword load and word store: err only, stays idle
    issue(1'b0, 1'b0, LSU_HALF, 1'b0, 32'h21, 32'd0, 5'd5, c0);
    push(mk(1'b0, K_ERR, c0 + 16'd1, 16'd0, 32'd0, 5'd0));
    check("mis_ready_c1", {31'd0, ready_a}, 32'd1);
    check("mis_state_c1", 32'(dbg_a), 32'(ST_IDLE));
    drain();
    issue(1'b0, 1'b1, LSU_WORD, 1'b0, 32'h22, 32'h5555_5555, 5'd0, c0);
    push(mk(1'b0, K_ERR, c0 + 16'd1, 16'd0, 32'd0, 5'd0));
    drain();

    // Latency 3, back-to-back word loads: responses in C5 and C10
    issue(1'b1, 1'b0, LSU_WORD, 1'b0, 32'h40, 32'd0, 5'd7, c0);
    push(mk(1'b1, K_RD, c0 + 16'd1, 16'h40, 32'd0, 5'd0));
    push(mk(1'b1, K_RESP, c0 + 16'd5, 16'd0, 32'd2, 5'd7));
    issue(1'b1, 1'b0, LSU_WORD, 1'b0, 32'h44, 32'd0, 5'd8, c1);
    check("b2b_accept_cycle", {16'd0, c1}, {16'd0, c0 + 16'd5});
    push(mk(1'b1, K_RD, c0 + 16'd6, 16'h44, 32'd0, 5'd0));
    push(mk(1'b1, K_RESP, c0 + 16'd10, 16'd0, 32'd14, 5'd8));
    drain();

    // Reset during RD_WAIT of a byte store: no write may follow
    issue(1'b0, 1'b1, LSU_BYTE, 1'b0, 32'h25, 32'h0000_00CD, 5'd0, c0);
    push(mk(1'b0, K_RD, c0 + 16'd1, 16'h24, 32'd0, 5'd0));
    @(posedge clk);
    #1;
    check("rmw_state_c2", 32'(dbg_a), 32'(ST_RD_WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_rd", {31'd0, mrd_a}, 32'd0);
    check("mid_rst_wr", {31'd0, mwr_a}, 32'd0);
    check("mid_rst_resp", {31'd0, resp_valid_a}, 32'd0);
    check("mid_rst_addr", maddr_a, 32'd0);
    check("mid_rst_wdata", mwdata_a, 32'd0);
    check("mid_rst_ready", {31'd0, ready_a}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drain();
    check("post_rst_ready", {31'd0, ready_a}, 32'd1);
    check("post_rst_state", 32'(dbg_a), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
